// File: rtl/clk_div_pkg.sv
// Shared constants, load-FSM state type and a divisor helper for clk_div_prog.
// Optional build macro used by this block: CLK_DIV_SHADOW_EN.
package clk_div_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  typedef enum logic {S_IDLE, S_PEND} ld_state_e;

  // Terminal count that gives an output frequency of hz from CLK_HZ.
  function automatic logic [31:0] term_for_hz(input logic [31:0] hz);
    return CLK_HZ / (32'd2 * hz) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_load_ctrl.sv
// Divisor load path: handshake, optional shadow register and commit FSM.
// CLK_DIV_SHADOW_EN defers the commit to the next terminal cycle or sync_clr.
module clk_div_load_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned        CNT_W        = 32,
  parameter logic [CNT_W-1:0]   DEFAULT_TERM = CNT_W'(249_999)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
  input  logic             term_hit,
  input  logic             sync_clr,
  output logic             div_ready,
  output logic [CNT_W-1:0] term_cur,
  output logic             restart
);

  logic [CNT_W-1:0] term_q, term_d;
  logic             xfer;

  assign xfer     = div_valid && div_ready;
  assign term_cur = term_q;

`ifdef CLK_DIV_SHADOW_EN
  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             unused_xfer_tie;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    term_d   = term_q;
    case (state_q)
      S_IDLE: if (xfer) begin
        shadow_d = div_value;
        state_d  = S_PEND;
      end
      // Commit only at a phase boundary so the running half-period keeps the old T.
      S_PEND: if (term_hit || sync_clr) begin
        term_d  = shadow_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      term_q   <= DEFAULT_TERM;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      term_q   <= term_d;
    end
  end

  assign div_ready       = (state_q == S_IDLE);
  assign restart         = 1'b0;
  assign unused_xfer_tie = 1'b0;
`else
  logic unused_ctrl;

  always_comb begin
    term_d = term_q;
    if (xfer) term_d = div_value;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) term_q <= DEFAULT_TERM;
    else          term_q <= term_d;
  end

  assign div_ready   = 1'b1;
  assign restart     = xfer;
  assign unused_ctrl = term_hit ^ sync_clr;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with toggle/rise tick strobes.
// Build with CLK_DIV_SHADOW_EN for glitch-free (deferred) divisor loads.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_TERM = CNT_W'(249_999)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             rise_tick,
  output logic [CNT_W-1:0] term_cur
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             rise_q, rise_d;
  logic             term_hit, restart;

  // >= rather than == so a shrinking T can never strand cnt above it.
  assign term_hit = en && !sync_clr && (cnt_q >= term_cur);

  clk_div_load_ctrl #(
    .CNT_W        (CNT_W),
    .DEFAULT_TERM (DEFAULT_TERM)
  ) u_load (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .div_valid (div_valid),
    .div_value (div_value),
    .term_hit  (term_hit),
    .sync_clr  (sync_clr),
    .div_ready (div_ready),
    .term_cur  (term_cur),
    .restart   (restart)
  );

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    rise_d    = 1'b0;
    if (sync_clr) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (term_hit) begin
      cnt_d     = '0;
      clk_out_d = !clk_out_q;
      tick_d    = 1'b1;
      rise_d    = !clk_out_q;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (restart) cnt_d = '0;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      rise_q    <= rise_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign rise_tick = rise_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider / tick generator for display scanning, debouncing and game-tick timing.
- Produces a 50%-duty divided clock plus single-cycle enable pulses, all on the system clock domain.
- Divisor is loadable through a valid/ready handshake.
- Has enable and synchronous-clear controls; reset divisor gives 200 Hz from 100 MHz.

Parameters:
- CNT_W, 32, width of the half-period counter and terminal register.
- DEFAULT_TERM, 249_999, terminal count after reset; half-period = DEFAULT_TERM+1 input cycles.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; low freezes the divider.
- sync_clr  input  1  synchronous restart of the phase.
- div_valid  input  1  new terminal count offered.
- div_value  input  CNT_W  new terminal count (half-period minus 1).
- div_ready  output  1  divider can accept div_value.
- clk_out  output  1  divided clock, period 2*(T+1) input cycles.
- tick  output  1  one-cycle pulse on every clk_out toggle.
- rise_tick  output  1  one-cycle pulse when clk_out goes 0->1.
- term_cur  output  CNT_W  terminal count T currently in use.

Behaviour:
- Reset (reset_n low, async):
  - cnt=0, clk_out=0, tick=0, rise_tick=0.
  - term_cur=DEFAULT_TERM, div_ready=1, no load pending.
- All outputs are registered. tick and rise_tick assert in the same cycle that clk_out changes.
- Counting, when en=1 and no sync_clr:
  - If cnt >= T: cnt<=0, clk_out toggles, tick=1, and rise_tick=1 if the new clk_out is 1.
  - Otherwise cnt<=cnt+1; tick and rise_tick are 0.
  - The >= compare guarantees no counter wrap-around if T shrinks below cnt.
- T=0 is legal: clk_out = clk_in/2, and tick is high every cycle.
- en=0: cnt and clk_out hold; tick and rise_tick are 0. The handshake is still serviced.
- sync_clr=1 has priority over en:
  - cnt<=0, clk_out<=0, tick and rise_tick are 0.
  - A pending load is committed in this cycle.
- Handshake: a transfer happens when div_valid && div_ready. div_value is sampled in that cycle. The source must hold div_value while div_valid=1 && div_ready=0.
- Load without shadow (macro undefined):
  - div_ready is always 1.
  - On transfer: term_cur<=div_value and cnt<=0; clk_out holds.
  - If the transfer coincides with a terminal cycle, the toggle still happens and the counter restarts under the new T.
- Reset asserted mid-period aborts immediately to reset values. A pending load is discarded.

Optional Feature:
- Macro: CLK_DIV_SHADOW_EN.
- Defined: glitch-free load via a 2-state FSM.
  - IDLE: div_ready=1. A transfer captures div_value into a shadow register and moves to PEND.
  - PEND: div_ready=0. At the next terminal cycle (cnt>=T, en=1) or on sync_clr, term_cur<=shadow and the FSM returns to IDLE.
  - The current half-period always completes with the old T.
  - div_ready returns to 1 the cycle after the commit.
  - Reset returns the FSM to IDLE.
- Undefined: loads are immediate, as described in Behaviour.

Decomposition:
- Package clk_div_pkg holds:
  - localparam CLK_HZ=100_000_000.
  - Helper function term_for_hz(hz) = CLK_HZ/(2*hz)-1.
  - Shadow FSM state typedef {S_IDLE, S_PEND}.
- One sub-module is natural: clk_div_load_ctrl, which owns the handshake, shadow register and FSM, and drives term_cur and a restart strobe into the counter core.

Test Plan:
- Reset then en=1: first clk_out rise at cycle 250_000, fall at 500_000; tick high only on those cycles; rise_tick only on the rise.
- Load T=3 (no shadow) at an arbitrary cnt: cnt restarts at 0; clk_out toggles every 4 cycles thereafter; term_cur=3 the next cycle.
- Load T=0, then load T=1 while cnt=5 of T=9: no skipped or extra toggle; counter never exceeds T.
- en low for 10 cycles mid-period: clk_out and cnt frozen, tick=0; counting resumes from the held cnt.
- sync_clr while clk_out=1, coincident with a terminal cycle: clk_out=0, cnt=0, no tick.
- With CLK_DIV_SHADOW_EN, T=9, load 2 at cnt=3:
  - div_ready=0 until the terminal cycle.
  - The old half-period is 10 cycles; subsequent half-periods are 3 cycles.
  - A second div_valid during PEND is stalled, then accepted after ready returns.
